// File: rtl/aes_pkg.sv
// Shared AES scheduler definitions: size codes, round lookups, FSM encoding and widths.
package aes_pkg;

    localparam int BLOCK_W     = 128;
    localparam int KEY_W       = 256;
    localparam int KE_LAT_DEF  = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        SIZE_128 = 2'b00,
        SIZE_192 = 2'b01,
        SIZE_256 = 2'b10,
        SIZE_ILL = 2'b11
    } aes_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_KEYEXP = 2'b01,
        ST_RUN    = 2'b10,
        ST_RESP   = 2'b11
    } sched_state_e;

    function automatic logic [3:0] size_nk(input logic [1:0] size);
        logic [3:0] nk;
        case (size)
            SIZE_128: nk = 4'd4;
            SIZE_192: nk = 4'd6;
            SIZE_256: nk = 4'd8;
            default:  nk = 4'd4;
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] size_nr(input logic [1:0] size);
        logic [3:0] nr;
        case (size)
            SIZE_128: nr = 4'd10;
            SIZE_192: nr = 4'd12;
            SIZE_256: nr = 4'd14;
            default:  nr = 4'd10;
        endcase
        return nr;
    endfunction

    // Keys are MSB-aligned, so only the upper bits take part in the cache compare.
    function automatic logic [KEY_W-1:0] key_mask(input logic [1:0] size);
        logic [KEY_W-1:0] m;
        case (size)
            SIZE_128: m = {{128{1'b1}}, {128{1'b0}}};
            SIZE_192: m = {{192{1'b1}}, {64{1'b0}}};
            default:  m = {KEY_W{1'b1}};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic last_grant_r;

    // Pick the requester that did not win last time when both ask
    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (!en) begin
            grant  = 2'b00;
            gnt_id = 1'b0;
        end else if (req == 2'b11) begin
            gnt_id = ~last_grant_r;
            grant  = last_grant_r ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt_id = 1'b0;
            grant  = 2'b01;
        end else if (req[1]) begin
            gnt_id = 1'b1;
            grant  = 2'b10;
        end else begin
            grant  = 2'b00;
            gnt_id = 1'b0;
        end
    end

    // Remember the most recent winner
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (grant != 2'b00) begin
            last_grant_r <= gnt_id;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one KeyExpansion and one cipher core pair between two requesters,
// skipping key expansion when the key and size match the last expanded key.
module aes_job_scheduler
    import aes_pkg::*;
#(
    parameter int KE_LAT  = KE_LAT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_dir,
    input  logic [3:0]           req_size,
    input  logic [2*KEY_W-1:0]   req_key,
    input  logic [2*BLOCK_W-1:0] req_data,
    output logic                 ke_cs_n,
    output logic [3:0]           ke_Nk,
    output logic [3:0]           ke_Nr,
    output logic [KEY_W-1:0]     ke_key,
    output logic                 core_cs_enc,
    output logic                 core_cs_dec,
    output logic [BLOCK_W-1:0]   core_init,
    input  logic                 core_flag,
    input  logic [BLOCK_W-1:0]   core_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic                 rsp_err,
    output logic [BLOCK_W-1:0]   rsp_data
);

    localparam int KE_CW  = $clog2(KE_LAT + 1);
    localparam int RUN_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_e        state_r, state_s;
    logic [1:0]          grant_s;
    logic                sel_id_s, sel_dir_s, run_dir_s;
    logic [1:0]          sel_size_s;
    logic [KEY_W-1:0]    sel_key_s;
    logic [BLOCK_W-1:0]  sel_data_s;
    logic                arb_en_s, cache_hit_s;
    logic                load_job_s, ke_start_s, ke_done_s, run_start_s;
    logic                done_ok_s, done_to_s, done_ill_s;
    logic                job_id_r, job_dir_r;
    logic [1:0]          job_size_r;
    logic [KE_CW-1:0]    ke_cnt_r;
    logic [RUN_CW-1:0]   run_cnt_r;
    logic                cache_valid_r;
    logic [1:0]          cache_size_r;
    logic [KEY_W-1:0]    cache_key_r;

    assign arb_en_s = (state_r == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en_s),
        .req    (req_valid),
        .grant  (grant_s),
        .gnt_id (sel_id_s)
    );

    assign sel_dir_s   = sel_id_s ? req_dir[1]                  : req_dir[0];
    assign sel_size_s  = sel_id_s ? req_size[3:2]               : req_size[1:0];
    assign sel_key_s   = sel_id_s ? req_key[2*KEY_W-1:KEY_W]    : req_key[KEY_W-1:0];
    assign sel_data_s  = sel_id_s ? req_data[2*BLOCK_W-1:BLOCK_W] : req_data[BLOCK_W-1:0];
    assign cache_hit_s = cache_valid_r && (sel_size_s == cache_size_r) &&
                         (((sel_key_s ^ cache_key_r) & key_mask(sel_size_s)) == {KEY_W{1'b0}});
    // A hit starts the core straight from IDLE, before the direction is latched
    assign run_dir_s   = (state_r == ST_IDLE) ? sel_dir_s : job_dir_r;

    // Next-state and one-cycle sequencing strobes
    always_comb begin
        state_s     = state_r;
        load_job_s  = 1'b0;
        ke_start_s  = 1'b0;
        ke_done_s   = 1'b0;
        run_start_s = 1'b0;
        done_ok_s   = 1'b0;
        done_to_s   = 1'b0;
        done_ill_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    load_job_s = 1'b1;
                    if (sel_size_s == SIZE_ILL) begin
                        done_ill_s = 1'b1;
                        state_s    = ST_RESP;
                    end else if (cache_hit_s) begin
                        run_start_s = 1'b1;
                        state_s     = ST_RUN;
                    end else begin
                        ke_start_s = 1'b1;
                        state_s    = ST_KEYEXP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (ke_cnt_r == KE_CW'(KE_LAT)) begin
                    ke_done_s   = 1'b1;
                    run_start_s = 1'b1;
                    state_s     = ST_RUN;
                end else begin
                    state_s = ST_KEYEXP;
                end
            end
            ST_RUN: begin
                // A flag arriving together with the timeout still counts as success
                if (core_flag) begin
                    done_ok_s = 1'b1;
                    state_s   = ST_RESP;
                end else if (run_cnt_r == RUN_CW'(TIMEOUT - 1)) begin
                    done_to_s = 1'b1;
                    state_s   = ST_RESP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant pulse and job latch
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 2'b00;
            job_id_r   <= 1'b0;
            job_dir_r  <= 1'b0;
            job_size_r <= 2'b00;
            ke_Nk      <= 4'd4;
            ke_Nr      <= 4'd10;
            ke_key     <= {KEY_W{1'b0}};
            core_init  <= {BLOCK_W{1'b0}};
        end else begin
            req_ready <= grant_s;
            if (load_job_s) begin
                job_id_r   <= sel_id_s;
                job_dir_r  <= sel_dir_s;
                job_size_r <= sel_size_s;
                ke_Nk      <= size_nk(sel_size_s);
                ke_Nr      <= size_nr(sel_size_s);
                ke_key     <= sel_key_s;
                core_init  <= sel_data_s;
            end else begin
                job_id_r <= job_id_r;
            end
        end
    end

    // Key expansion pulse, settle counter and key cache
    always_ff @(posedge clk) begin
        if (rst) begin
            ke_cs_n       <= 1'b1;
            ke_cnt_r      <= {KE_CW{1'b0}};
            cache_valid_r <= 1'b0;
            cache_size_r  <= 2'b00;
            cache_key_r   <= {KEY_W{1'b0}};
        end else begin
            ke_cs_n <= ~ke_start_s;
            if (ke_start_s) begin
                ke_cnt_r <= {KE_CW{1'b0}};
            end else if ((state_r == ST_KEYEXP) && !ke_done_s) begin
                ke_cnt_r <= ke_cnt_r + KE_CW'(1);
            end else begin
                ke_cnt_r <= ke_cnt_r;
            end
            if (ke_start_s || done_to_s) begin
                cache_valid_r <= 1'b0;
            end else if (ke_done_s) begin
                cache_valid_r <= 1'b1;
                cache_size_r  <= job_size_r;
                cache_key_r   <= ke_key & key_mask(job_size_r);
            end else begin
                cache_valid_r <= cache_valid_r;
            end
        end
    end

    // Cipher run enables and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            core_cs_enc <= 1'b0;
            core_cs_dec <= 1'b0;
            run_cnt_r   <= {RUN_CW{1'b0}};
        end else if (run_start_s) begin
            core_cs_enc <= ~run_dir_s;
            core_cs_dec <= run_dir_s;
            run_cnt_r   <= {RUN_CW{1'b0}};
        end else if (done_ok_s || done_to_s) begin
            core_cs_enc <= 1'b0;
            core_cs_dec <= 1'b0;
            run_cnt_r   <= {RUN_CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            run_cnt_r <= run_cnt_r + RUN_CW'(1);
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Response payload, held until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= {BLOCK_W{1'b0}};
        end else if (done_ok_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= job_id_r;
            rsp_err   <= 1'b0;
            rsp_data  <= core_result;
        end else if (done_to_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= job_id_r;
            rsp_err   <= 1'b1;
            rsp_data  <= {BLOCK_W{1'b0}};
        end else if (done_ill_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= sel_id_s;
            rsp_err   <= 1'b1;
            rsp_data  <= {BLOCK_W{1'b0}};
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

endmodule
